// File: rtl/la_mem_pkg.sv
// rtl/la_mem_pkg.sv - shared types and alignment check for the data RAM bridge
package la_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } bridge_state_t;

  function automatic logic ALIGN_ERR(input mem_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    ALIGN_ERR = 1'b0;
      SZ_H:    ALIGN_ERR = lo[0];
      SZ_W:    ALIGN_ERR = (lo != 2'b00);
      default: ALIGN_ERR = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_bridge_lane_merge.sv
// rtl/data_ram_bridge_lane_merge.sv - byte/half lane extract for loads and lane insert for stores
module lane_merge
  import la_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_wdata;
    case (mem_size_t'(i_size))
      SZ_B: begin
        o_load   = {{24{i_sign & w_byte[7]}}, w_byte};
        o_merged = i_word;
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_H: begin
        o_load   = {{16{i_sign & w_half[15]}}, w_half};
        o_merged = i_word;
        o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load   = i_word;
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_ram_bridge.sv
// rtl/data_ram_bridge.sv - sequential LSU to word-wide single-port data_ram bridge
module data_ram_bridge
  import la_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_addr_ok,
  output logic                  o_data_ok,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_ram_a,
  output logic [DATA_WIDTH-1:0] o_ram_d,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_spo
);

  bridge_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_word_a;
  logic [1:0]            r_addr_lo;
  mem_size_t             r_size;
  logic                  r_sign;
  logic [31:0]           r_wdata;
  logic [31:0]           r_wbuf;
  logic [31:0]           r_result;
  logic                  r_err;

  logic [31:0]           w_load;
  logic [31:0]           w_merged;
  logic                  w_unused_addr;

  // Bits above the RAM depth are dropped so the address wraps.
  assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];

  lane_merge u_lane_merge (
    .i_word    (i_ram_spo),
    .i_addr_lo (r_addr_lo),
    .i_size    (r_size),
    .i_sign    (r_sign),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_word_a  <= '0;
      r_addr_lo <= '0;
      r_size    <= SZ_B;
      r_sign    <= 1'b0;
      r_wdata   <= '0;
      r_wbuf    <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_word_a  <= i_addr[ADDR_WIDTH+1:2];
            r_addr_lo <= i_addr[1:0];
            r_size    <= mem_size_t'(i_size);
            r_sign    <= i_sign;
            r_wdata   <= i_wdata;
            r_result  <= '0;
            if (ALIGN_ERR(mem_size_t'(i_size), i_addr[1:0])) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else if (!i_wr) begin
              r_state <= ST_LOAD;
            end else if (mem_size_t'(i_size) == SZ_W) begin
              r_wbuf  <= i_wdata;
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_MERGE;
            end
          end
        end
        ST_LOAD: begin
          r_result <= w_load;
          r_state  <= ST_RESP;
        end
        ST_MERGE: begin
          r_wbuf  <= w_merged;
          r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_RESP;
        ST_RESP: begin
          // Clear response fields so rdata/err are only non-zero alongside data_ok.
          r_result <= '0;
          r_err    <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_addr_ok = (r_state == ST_IDLE) && !i_reset;
  assign o_data_ok = (r_state == ST_RESP) && !i_reset;
  assign o_ram_we  = (r_state == ST_WRITE) && !i_reset;
  assign o_rdata   = r_result;
  assign o_err     = r_err;
  assign o_ram_d   = r_wbuf;
  assign o_ram_a   = (r_state == ST_IDLE) ? i_addr[ADDR_WIDTH+1:2] : r_word_a;

endmodule

// File: doc/data_ram_bridge.md
# data_ram_bridge

Sequential bridge between the CPU load/store unit and the word-wide, single-port `data_ram`. It accepts byte, halfword and word requests over a req/addr_ok/data_ok handshake. It extracts and extends load data, and performs read-modify-write for sub-word stores, because the RAM writes whole words only and tristates its read data while `we` is high. It sits directly upstream of `data_ram` and drives its `a`, `d` and `we` inputs.

## Interface
- `ADDR_WIDTH`, 15: RAM word-address width; must match `data_ram`.
- `DATA_WIDTH`, 32: data width; fixed at 32.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: CPU request valid.
- `wr` in 1: 1 = store, 0 = load.
- `size` in 2: 0 byte, 1 half, 2 word, 3 reserved.
- `sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `addr_ok` out 1: request accepted this cycle.
- `data_ok` out 1: one-cycle completion pulse.
- `rdata` out 32: load result, valid with `data_ok`; 0 for stores and errors.
- `err` out 1: alignment/size error, valid with `data_ok`.
- `ram_a` out ADDR_WIDTH: to `data_ram.a`, equal to `addr[ADDR_WIDTH+1:2]` of the latched request.
- `ram_d` out 32: to `data_ram.d`.
- `ram_we` out 1: to `data_ram.we`.
- `ram_spo` in 32: from `data_ram.spo`; combinational read, valid only while `ram_we`=0.

## Operation
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE
  - `addr_ok = (state==IDLE) && !reset`.
  - On `req && addr_ok`, latch `addr`, `wr`, `size`, `sign` and `wdata`, then branch.
  - Error (size 3, half with `addr[0]`=1, or word with `addr[1:0]`≠0) → RESP with `err`=1. No RAM access.
  - Load → LOAD.
  - Word store → WRITE, with write buffer = `wdata`.
  - Byte/half store → MERGE.
- LOAD
  - `ram_we`=0.
  - Extract the lane selected by the latched `addr[1:0]`: byte at `addr[1:0]*8`, half at `addr[1]*16`.
  - Extend per `sign`, register into the result register → RESP.
- MERGE
  - `ram_we`=0.
  - Register `ram_spo` with the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]` → WRITE.
- WRITE
  - `ram_we`=1, `ram_d` = write buffer → RESP.
  - The RAM commits at the end of this cycle.
- RESP
  - `data_ok`=1, `rdata` = result register (0 for stores), `err` = latched error flag → IDLE.
- New requests are never accepted outside IDLE; `req` held high in other states is ignored until IDLE.
- `ram_a` holds the latched word address in every non-IDLE state. In IDLE it follows `addr` combinationally.
- Address bits above `ADDR_WIDTH+1` are ignored; the address wraps modulo RAM depth.

## Timing
- Request accepted in cycle 0; `data_ok` arrives:
  - word store or load: cycle 2;
  - byte/half store: cycle 3;
  - error: cycle 1.
- Back-to-back: next `addr_ok` is one cycle after `data_ok` (IDLE cycle).
- Reset values: state IDLE, `data_ok`=0, `err`=0, `rdata`=0, `ram_we`=0, `ram_d`=0, all latched registers 0.
- During reset, `addr_ok`=0.
- Reset mid-operation aborts immediately.
  - `ram_we = (state==WRITE) && !reset`, so a store in WRITE during a reset cycle is not committed.
  - No `data_ok` follows an aborted request.
- A load always observes any store that completed earlier, since the RAM write commits before RESP.

## Structure
- Package `la_mem_pkg`:
  - `mem_size_t` enum (SZ_B, SZ_H, SZ_W, SZ_RSV);
  - `bridge_state_t` enum;
  - `ALIGN_ERR` check function.
- Sub-module `lane_merge`: combinational. Inputs: word, `addr[1:0]`, `size`, `sign`, `wdata`. Outputs: extracted load value and merged store word. Used in the LOAD and MERGE paths.
- FSM and registers live in `data_ram_bridge`. `data_ram` itself is instantiated at SoC level, not inside this block.

## Test plan
- Word store `addr`=0x100, `wdata`=0xDEADBEEF, then word load 0x100 → `ram_we` high exactly 1 cycle at `ram_a`=0x40; load `data_ok` at cycle 2 with `rdata`=0xDEADBEEF.
- Preload word 0x40=0x11223344; byte store 0xAA to 0x102 → `ram_we` only in cycle 2; RAM word = 0x11AA3344; `data_ok` at cycle 3.
- Word 0x40=0x8000F0FF:
  - byte load 0x100 with `sign`=1 → 0xFFFFFFFF;
  - half load 0x102 with `sign`=0 → 0x00008000;
  - half load 0x102 with `sign`=1 → 0xFFFF8000.
- Half load 0x101 and word store 0x102 → `data_ok` and `err` at cycle 1, `ram_we` never asserted, `rdata`=0.
- `req` held high continuously with 4 loads queued → `addr_ok` pulses every 3 cycles; each `data_ok` is 2 cycles after its acceptance.
- Partial store with `reset` asserted in the WRITE cycle → `ram_we`=0, RAM word unchanged, no `data_ok`, `addr_ok` returns 1 the cycle after reset deasserts.
